// File: rtl/ex_div.sv
// Execute-stage RV32M divider: DIV/DIVU/REM/REMU, radix-2 restoring, one bit per cycle.
// Optional DIV_EARLY_OUT_EN: skip the loop when |dividend| < |divisor|.
module ex_div #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipeline_flush_i,
  input  logic [DATA_W-1:0] op_data1_i,
  input  logic [DATA_W-1:0] op_data2_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [31:0]       inst_i,
  output logic              div_busy_o,
  output logic              div_valid_o,
  output logic [DATA_W-1:0] div_result_o,
  output logic [REG_AW-1:0] div_rd_addr_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(DATA_W-1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;
  logic              neg_q;
  logic              neg_r;
  logic              is_rem;

  logic              div_op;
  logic              start;
  logic              sgn;
  logic              s1;
  logic              s2;
  logic              div_zero;
  logic              ovf;
  logic              early;
  logic              fast;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W-1:0] fast_res;
  logic [DATA_W-1:0] rem_sh;
  logic [DATA_W:0]   diff;
  logic              ge;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] quo_nx;
  logic [DATA_W-1:0] fin_res;
  logic              unused_bits;

  assign unused_bits = ^{inst_i[24:15], inst_i[11:7]};

  always_comb begin
    div_op = (inst_i[6:0] == 7'b0110011)
          && (inst_i[31:25] == 7'b0000001)
          && inst_i[14];
    start = (state == IDLE) && div_op && !pipeline_flush_i;
    div_busy_o = start || (state == BUSY);

    sgn  = ~inst_i[12];
    s1   = sgn & op_data1_i[DATA_W-1];
    s2   = sgn & op_data2_i[DATA_W-1];
    abs1 = s1 ? -op_data1_i : op_data1_i;
    abs2 = s2 ? -op_data2_i : op_data2_i;

    div_zero = (op_data2_i == '0);
    ovf      = sgn && (op_data1_i == MIN_NEG)
            && (op_data2_i == '1);
`ifdef DIV_EARLY_OUT_EN
    early = !div_zero && (abs1 < abs2);
`else
    early = 1'b0;
`endif
    fast = div_zero || ovf || early;

    // Early-out: quotient 0, remainder is the untouched dividend
    if (div_zero)
      fast_res = inst_i[13] ? op_data1_i : '1;
    else if (ovf)
      fast_res = inst_i[13] ? '0 : MIN_NEG;
    else
      fast_res = inst_i[13] ? op_data1_i : '0;

    // dvd shifts out dividend bits at the top, quotient bits in at the bottom
    rem_sh = {rem[DATA_W-2:0], dvd[DATA_W-1]};
    diff   = {1'b0, rem_sh} - {1'b0, dvs};
    ge     = ~diff[DATA_W];
    rem_nx = ge ? diff[DATA_W-1:0] : rem_sh;
    quo_nx = {dvd[DATA_W-2:0], ge};

    if (is_rem)
      fin_res = neg_r ? -rem_nx : rem_nx;
    else
      fin_res = neg_q ? -quo_nx : quo_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      dvd           <= '0;
      dvs           <= '0;
      rem           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      is_rem        <= 1'b0;
      div_valid_o   <= 1'b0;
      div_result_o  <= '0;
      div_rd_addr_o <= '0;
    end else begin
      div_valid_o <= 1'b0;
      if (pipeline_flush_i) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              div_rd_addr_o <= rd_addr_i;
              if (fast) begin
                div_result_o <= fast_res;
                div_valid_o  <= 1'b1;
                state        <= DONE;
              end else begin
                dvd    <= abs1;
                dvs    <= abs2;
                rem    <= '0;
                cnt    <= '0;
                neg_q  <= s1 ^ s2;
                neg_r  <= s1;
                is_rem <= inst_i[13];
                state  <= BUSY;
              end
            end
          end
          BUSY: begin
            dvd <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              div_result_o <= fin_res;
              div_valid_o  <= 1'b1;
              state        <= DONE;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div.
// Expected latencies follow DIV_EARLY_OUT_EN when it is defined.
module tb_ex_div;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;
  logic [31:0] inst;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [4:0]  rd_o;

  int n_chk  = 0;
  int n_fail = 0;

  ex_div dut (
    .clk              (clk),
    .rst              (rst),
    .pipeline_flush_i (flush),
    .op_data1_i       (a),
    .op_data2_i       (b),
    .rd_addr_i        (rd),
    .inst_i           (inst),
    .div_busy_o       (busy),
    .div_valid_o      (valid),
    .div_result_o     (result),
    .div_rd_addr_o    (rd_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [2:0] f3,
                                        input logic [4:0] rd_a);
    return {7'b0000001, 5'd2, 5'd1, f3, rd_a, 7'b0110011};
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic [4:0] rd_v, input logic [31:0] exp_res,
                        input int exp_lat);
    int lat = 0;
    int bad_busy = 0;
    @(posedge clk);
    #1;
    inst = rtype(f3, rd_v);
    a    = a_v;
    b    = b_v;
    rd   = rd_v;
    #1;
    chk({tag, "_v0"}, {31'b0, valid}, 32'd0);
    chk({tag, "_busy0"}, {31'b0, busy}, 32'd1);
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk);
      #2;
      if (busy !== (n < exp_lat)) bad_busy++;
      if (valid) lat = n;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, bad_busy, 0);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_rd"}, {27'b0, rd_o}, {27'b0, rd_v});
  endtask

  initial begin
    logic [31:0] prev;
    int vcnt;
    rst   = 1'b1;
    flush = 1'b0;
    inst  = NOP;
    a     = '0;
    b     = '0;
    rd    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_rd", {27'b0, rd_o}, 32'd0);
    rst = 1'b0;

    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
    run_op("rem_m7_2", F_REM, -32'sd7, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
    run_op("div_m7_2", F_DIV, -32'sd7, 32'd2, 5'd6, 32'hFFFF_FFFD, 33);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1,
           32'h8000_0000, 1);
    run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2,
           32'd0, 1);
    run_op("remu_5_0", F_REMU, 32'd5, 32'd0, 5'd3, 32'd5, 1);
    run_op("div_5_0", F_DIV, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF, 1);
    run_op("divu_3_10", F_DIVU, 32'd3, 32'd10, 5'd4, 32'd0, EO_LAT);
    run_op("rem_m3_10", F_REM, -32'sd3, 32'd10, 5'd4, 32'hFFFF_FFFD,
           EO_LAT);
    run_op("rem_7_m2", F_REM, 32'd7, -32'sd2, 5'd9, 32'd1, 33);
    run_op("div_7_m2", F_DIV, 32'd7, -32'sd2, 5'd9, 32'hFFFF_FFFD, 33);
    run_op("divu_x0", F_DIVU, 32'd9, 32'd2, 5'd0, 32'd4, 33);

    // Flush ten cycles into DIV 1000/3
    prev = 32'd4;
    @(posedge clk);
    #1;
    inst = rtype(F_DIV, 5'd7);
    a    = 32'd1000;
    b    = 32'd3;
    rd   = 5'd7;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) flush = 1'b1;
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    inst  = NOP;
    #1;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    vcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #2;
      if (valid) vcnt++;
    end
    chk("flush_nostrobe", vcnt, 0);
    chk("flush_res", result, prev);
    run_op("div_9_3", F_DIV, 32'd9, 32'd3, 5'd7, 32'd3, 33);

    run_op("b2b_divu", F_DIVU, 32'd20, 32'd6, 5'd8, 32'd3, 33);
    run_op("b2b_remu", F_REMU, 32'd20, 32'd6, 5'd8, 32'd2, 33);
    @(posedge clk);
    #1;
    inst = NOP;
    #1;
    chk("b2b_v_end", {31'b0, valid}, 32'd0);

    // Asynchronous reset in the middle of a divide
    @(posedge clk);
    #1;
    inst = rtype(F_DIVU, 5'd11);
    a    = 32'd100;
    b    = 32'd7;
    rd   = 5'd11;
    repeat (5) @(posedge clk);
    #1;
    rst  = 1'b1;
    inst = NOP;
    #1;
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_valid", {31'b0, valid}, 32'd0);
    chk("mrst_res", result, 32'd0);
    chk("mrst_rd", {27'b0, rd_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #2;
      if (valid) vcnt++;
    end
    chk("mrst_nostrobe", vcnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
